axi_buffer_rab_bram_prefetch: RTL and testbench
===============================================

Name: axi_buffer_rab_bram_prefetch

Overview:
First-word-fall-through FIFO for AXI channel payloads in the RAB datapath, built on a one-cycle-latency simple dual-port BRAM.
Successor to the single-pointer BRAM buffer:
- a 2-entry registered prefetch stage decouples the BRAM read latency from the consumer, so `data_out` is always a flop output;
- an empty-FIFO bypass gives 1-cycle write-to-output latency;
- writes are qualified by `ready_out`, so there is no write-while-full corruption;
- non-power-of-two depth;
- fill level and almost-full outputs for upstream throttling.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- BUFFER_DEPTH, 512, BRAM entries, ≥ 2, any integer (not restricted to power of two).
- ALMOST_FULL_THRESH, BUFFER_DEPTH-4, almost_full asserts when fill_level ≥ this value; legal range 1..BUFFER_DEPTH+2.
- LOG_BUFFER_DEPTH, $clog2(BUFFER_DEPTH), localparam, pointer width.
- LEVEL_WIDTH, $clog2(BUFFER_DEPTH+3), localparam, width of fill_level.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  upstream payload.
- valid_in  in  1  upstream valid.
- ready_out  out  1  upstream ready.
- data_out  out  DATA_WIDTH  downstream payload, registered.
- valid_out  out  1  downstream valid.
- ready_in  in  1  downstream ready.
- flush_entries  in  1  synchronous clear of all contents.
- fill_level  out  LEVEL_WIDTH  words held: BRAM + in-flight read + prefetch stage.
- almost_full  out  1  fill_level ≥ ALMOST_FULL_THRESH.

Behaviour:
- Reset is synchronous: one clock with rst=1 forces all pointers, counters and valid bits to 0.
  - After reset: valid_out=0, ready_out=1, fill_level=0, almost_full=0 (1 only if ALMOST_FULL_THRESH is 0, which is illegal). data_out content is don't-care.
- Handshakes:
  - push = valid_in & ready_out.
  - pop = valid_out & ready_in.
  - valid_out must not depend combinationally on ready_in.
  - ready_out = (ram_count != BUFFER_DEPTH), registered-equivalent (derived from flops only).
- State held:
  - ram_count (0..BUFFER_DEPTH).
  - ptr_in, ptr_out: wrap from BUFFER_DEPTH-1 to 0.
  - rd_pend: 1-bit, BRAM read issued last cycle.
  - out_cnt (0..2): prefetch stage occupancy. Head is slot 0; data_out = slot 0; valid_out = (out_cnt != 0).
- Bypass, when ram_count==0, rd_pend==0 and (out_cnt − pop) < 2:
  - a push writes directly into the prefetch stage at the next free slot;
  - it is not written to BRAM;
  - data is visible on data_out the cycle after the push.
- Otherwise a push writes BRAM[ptr_in]; ptr_in++, ram_count++.
- BRAM read issue: when ram_count > 0 and (out_cnt + rd_pend − pop) < 2:
  - issue read of ptr_out; ptr_out++, ram_count--, rd_pend←1.
  - Returned data lands in the prefetch stage the following cycle.
- Ordering: bypass is only taken when no older word is in the BRAM or in flight, so order is strictly FIFO.
- Simultaneous push and BRAM read in the same cycle:
  - ram_count is unchanged;
  - ptr_in ≠ ptr_out is guaranteed because ram_count is in 1..BUFFER_DEPTH-1 when both happen, so no read-during-write hazard exists.
- Pop with out_cnt==2: slot 1 shifts to slot 0 in the same edge that consumes slot 0; arriving read data fills the freed slot.
- Throughput: sustains 1 push + 1 pop per cycle indefinitely, at any fill level.
- Latency: 1 cycle via bypass; 2 cycles when the word comes from BRAM with the prefetch stage empty.
- Capacity is BUFFER_DEPTH+2. ready_out drops only when the BRAM itself is full.
- fill_level = ram_count + rd_pend + out_cnt, registered. almost_full is computed from the registered fill_level.
- flush_entries=1:
  - next cycle all state is 0, as for reset;
  - push and pop presented in that cycle are discarded;
  - an in-flight read return is dropped.
- rst and flush_entries mid-operation have identical effect.

Decomposition:
- Package axi_rab_buffer_pkg: function for level width (clog2(depth+3)); localparam PREFETCH_DEPTH=2.
- Sub-module rab_bram_sdp: one write port, one read port, 1-cycle registered read, no reset on the array, inferable as BRAM.
- FIFO control and the prefetch stage stay in the top module.

Test Plan:
- Reset then a single push of 0xA5A5_0001 into an empty FIFO with ready_in=1 → valid_out=1 with data 0xA5A5_0001 exactly 1 cycle later (bypass); fill_level returns to 0.
- ready_in=0; push 515 words 0..514 with BUFFER_DEPTH=512 → ready_out drops after word 513; 514 words accepted; fill_level=514; almost_full asserted from fill_level 508. Then drain → words 0..513 in order, no gaps.
- Continuous push and pop every cycle for 2000 words, BUFFER_DEPTH=5 (non-power-of-two, exercises wrap) → output sequence equals input; valid_out never drops after the first word.
- Random valid_in/ready_in at 50% each, 10k words, DEPTH=7 → scoreboard match; fill_level equals the model's count every cycle; ready_out=0 only when the BRAM is full.
- Fill with 100 words, then assert flush_entries together with valid_in=1 and ready_in=1 → next cycle valid_out=0, fill_level=0; a subsequent push of 0x1234 appears after 1 cycle.
- Assert rst for one cycle while a BRAM read is in flight → next cycle all outputs at reset values; no stale word appears afterwards.

Source files
------------

// File: rtl/axi_rab_buffer_pkg.sv
// axi_rab_buffer_pkg: shared sizing helpers for the RAB prefetching BRAM buffer
// No ports; provides the prefetch stage depth and the fill-level width function.
package axi_rab_buffer_pkg;
    localparam int PREFETCH_DEPTH = 2;
    function automatic int level_width(input int depth);
        return $clog2(depth + 3);
    endfunction
endpackage

// File: rtl/axi_buffer_rab_bram_prefetch_sdp.sv
// rab_bram_sdp: simple dual-port RAM with one-cycle registered read, no array reset
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request; rdata_o read data one cycle after re_i.
module rab_bram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_buffer_rab_bram_prefetch.sv
// axi_buffer_rab_bram_prefetch: FWFT FIFO on a 1-cycle BRAM with 2-entry registered prefetch stage
// Ports: clk/rst (sync, active high); data_in/valid_in/ready_out upstream; data_out/valid_out/ready_in
// downstream; flush_entries clears all contents; fill_level words held; almost_full = fill_level >= threshold.
module axi_buffer_rab_bram_prefetch
    import axi_rab_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUFFER_DEPTH = 512,
    parameter int ALMOST_FULL_THRESH = BUFFER_DEPTH - 4,
    localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
    localparam int LEVEL_WIDTH = level_width(BUFFER_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    input  logic                   flush_entries,
    output logic [LEVEL_WIDTH-1:0] fill_level,
    output logic                   almost_full
);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    logic [CW-1:0]               ram_count_q, ram_count_d;
    logic [LOG_BUFFER_DEPTH-1:0] ptr_in_q, ptr_in_d, ptr_out_q, ptr_out_d;
    logic                        rd_pend_q, rd_pend_d;
    logic [1:0]                  out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0]       slot0_q, slot0_d, slot1_q, slot1_d;
    logic [LEVEL_WIDTH-1:0]      fill_q, fill_d;
    logic [DATA_WIDTH-1:0]       rdata, in_data;
    logic [1:0]                  kept;
    logic                        push, pop, bypass, ram_wr, rd_issue, incoming;
    assign ready_out = ram_count_q != CW'(BUFFER_DEPTH);
    assign valid_out = out_cnt_q != 2'd0;
    assign data_out = slot0_q;
    assign fill_level = fill_q;
    assign almost_full = fill_q >= LEVEL_WIDTH'(ALMOST_FULL_THRESH);
    assign push = valid_in & ready_out;
    assign pop = valid_out & ready_in;
    // Prefetch occupancy once this cycle's pop has been taken out.
    assign kept = out_cnt_q - {1'b0, pop};
    // Bypass only when nothing older sits in the BRAM or in flight, keeping strict FIFO order.
    assign bypass = push & (ram_count_q == '0) & ~rd_pend_q & (kept < 2'(PREFETCH_DEPTH));
    assign ram_wr = push & ~bypass;
    // Reserve a prefetch slot for every read in flight so returning data always has room.
    assign rd_issue = (ram_count_q != '0) & ((3'(kept) + 3'(rd_pend_q)) < 3'(PREFETCH_DEPTH));
    // A read return and a bypass never coincide: bypass requires no read in flight.
    assign incoming = rd_pend_q | bypass;
    assign in_data = rd_pend_q ? rdata : data_in;
    always_comb begin
        ram_count_d = ram_count_q + CW'(ram_wr) - CW'(rd_issue);
        ptr_in_d = ram_wr ? (ptr_in_q == LAST ? '0 : ptr_in_q + LOG_BUFFER_DEPTH'(1)) : ptr_in_q;
        ptr_out_d = rd_issue ? (ptr_out_q == LAST ? '0 : ptr_out_q + LOG_BUFFER_DEPTH'(1)) : ptr_out_q;
        rd_pend_d = rd_issue;
        out_cnt_d = kept + 2'(incoming);
        slot0_d = (incoming && kept == 2'd0) ? in_data : (pop ? slot1_q : slot0_q);
        slot1_d = (incoming && kept != 2'd0) ? in_data : slot1_q;
        fill_d = LEVEL_WIDTH'(ram_count_d) + LEVEL_WIDTH'(rd_pend_d) + LEVEL_WIDTH'(out_cnt_d);
    end
    always_ff @(posedge clk) begin
        if (rst || flush_entries) begin
            ram_count_q <= '0;
            ptr_in_q <= '0;
            ptr_out_q <= '0;
            rd_pend_q <= 1'b0;
            out_cnt_q <= '0;
            fill_q <= '0;
        end else begin
            ram_count_q <= ram_count_d;
            ptr_in_q <= ptr_in_d;
            ptr_out_q <= ptr_out_d;
            rd_pend_q <= rd_pend_d;
            out_cnt_q <= out_cnt_d;
            fill_q <= fill_d;
        end
    end
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end
    rab_bram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BUFFER_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_wr),
        .waddr_i(ptr_in_q),
        .wdata_i(data_in),
        .re_i   (rd_issue),
        .raddr_i(ptr_out_q),
        .rdata_o(rdata)
    );
endmodule

// File: tb/tb_axi_buffer_rab_bram_prefetch.sv
// tb_axi_buffer_rab_bram_prefetch: directed and random checks of the prefetching BRAM FIFO
module tb_axi_buffer_rab_bram_prefetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;

    logic [31:0] d0_i = '0, d0_o;
    logic v0_i = 0, r0_i = 0, f0 = 0, r0_o, v0_o, af0;
    logic [9:0] lv0;
    logic [31:0] d1_i = '0, d1_o;
    logic v1_i = 0, r1_i = 0, r1_o, v1_o, af1;
    logic [2:0] lv1;
    logic [31:0] d2_i = '0, d2_o;
    logic v2_i = 0, r2_i = 0, r2_o, v2_o, af2;
    logic [3:0] lv2;

    axi_buffer_rab_bram_prefetch #(.DATA_WIDTH(32), .BUFFER_DEPTH(512)) u0 (
        .clk(clk), .rst(rst), .data_in(d0_i), .valid_in(v0_i), .ready_out(r0_o),
        .data_out(d0_o), .valid_out(v0_o), .ready_in(r0_i), .flush_entries(f0),
        .fill_level(lv0), .almost_full(af0));
    axi_buffer_rab_bram_prefetch #(.DATA_WIDTH(32), .BUFFER_DEPTH(5)) u1 (
        .clk(clk), .rst(rst), .data_in(d1_i), .valid_in(v1_i), .ready_out(r1_o),
        .data_out(d1_o), .valid_out(v1_o), .ready_in(r1_i), .flush_entries(1'b0),
        .fill_level(lv1), .almost_full(af1));
    axi_buffer_rab_bram_prefetch #(.DATA_WIDTH(32), .BUFFER_DEPTH(7)) u2 (
        .clk(clk), .rst(rst), .data_in(d2_i), .valid_in(v2_i), .ready_out(r2_o),
        .data_out(d2_o), .valid_out(v2_o), .ready_in(r2_i), .flush_entries(1'b0),
        .fill_level(lv2), .almost_full(af2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    typedef struct {
        logic        vi;
        logic [31:0] di;
        logic        ri;
        logic        fl;
        logic        evo;
        logic [31:0] ed;
        logic [9:0]  elv;
    } vec_t;
    vec_t tab[12];

    logic [31:0] q[$];
    int acc, tx, rx, sent, got;

    initial begin
        tab[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 10'd1};
        tab[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         10'd0};
        tab[2]  = '{1'b1, 32'h11,        1'b0, 1'b0, 1'b1, 32'h11,        10'd1};
        tab[3]  = '{1'b1, 32'h22,        1'b0, 1'b0, 1'b1, 32'h11,        10'd2};
        tab[4]  = '{1'b1, 32'h33,        1'b0, 1'b0, 1'b1, 32'h11,        10'd3};
        tab[5]  = '{1'b1, 32'h44,        1'b1, 1'b0, 1'b1, 32'h22,        10'd3};
        tab[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h33,        10'd2};
        tab[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h44,        10'd1};
        tab[8]  = '{1'b1, 32'h55,        1'b1, 1'b0, 1'b1, 32'h55,        10'd1};
        tab[9]  = '{1'b1, 32'h66,        1'b1, 1'b1, 1'b0, 32'h0,         10'd0};
        tab[10] = '{1'b1, 32'h1234,      1'b0, 1'b0, 1'b1, 32'h1234,      10'd1};
        tab[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         10'd0};

        repeat (2) @(negedge clk);
        chk("rst_valid", v0_o, 0);
        chk("rst_ready", r0_o, 1);
        chk("rst_level", lv0, 0);
        chk("rst_af", af0, 0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            v0_i = tab[i].vi; d0_i = tab[i].di; r0_i = tab[i].ri; f0 = tab[i].fl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), v0_o, tab[i].evo);
            if (tab[i].evo) chk($sformatf("vec%0d_data", i), d0_o, tab[i].ed);
            chk($sformatf("vec%0d_level", i), lv0, tab[i].elv);
            chk($sformatf("vec%0d_ready", i), r0_o, 1);
            chk($sformatf("vec%0d_af", i), af0, 0);
        end
        v0_i = 0; r0_i = 0; f0 = 0;

        acc = 0;
        for (int w = 0; w < 515; w++) begin
            @(negedge clk);
            chk("fill_level", lv0, acc);
            chk("fill_af", af0, acc >= 508);
            chk("fill_ready", r0_o, w < 514);
            v0_i = 1; d0_i = w;
            if (r0_o) acc++;
        end
        @(negedge clk);
        v0_i = 0;
        chk("fill_accepted", acc, 514);
        chk("full_level", lv0, 514);
        chk("full_af", af0, 1);
        chk("full_ready", r0_o, 0);
        r0_i = 1;
        for (int k = 0; k < 514; k++) begin
            if (k > 0) @(negedge clk);
            chk("drain_valid", v0_o, 1);
            chk("drain_data", d0_o, k);
        end
        @(negedge clk);
        chk("drained_valid", v0_o, 0);
        chk("drained_level", lv0, 0);

        r0_i = 0;
        for (int w = 0; w < 100; w++) begin
            v0_i = 1; d0_i = 32'h100 + w;
            @(negedge clk);
        end
        chk("pre_flush_level", lv0, 100);
        v0_i = 1; d0_i = 32'hDEAD; r0_i = 1; f0 = 1;
        @(negedge clk);
        f0 = 0;
        chk("flush_valid", v0_o, 0);
        chk("flush_level", lv0, 0);
        v0_i = 1; d0_i = 32'h1234; r0_i = 0;
        @(negedge clk);
        v0_i = 0;
        chk("post_flush_valid", v0_o, 1);
        chk("post_flush_data", d0_o, 32'h1234);
        chk("post_flush_level", lv0, 1);
        r0_i = 1;
        @(negedge clk);
        chk("post_flush_empty", v0_o, 0);

        r0_i = 0;
        for (int w = 0; w < 5; w++) begin
            v0_i = 1; d0_i = 32'hB0 + w;
            @(negedge clk);
        end
        v0_i = 0; r0_i = 1;
        @(negedge clk);
        chk("inflight_level", lv0, 4);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst2_valid", v0_o, 0);
        chk("rst2_ready", r0_o, 1);
        chk("rst2_level", lv0, 0);
        chk("rst2_af", af0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst2_no_stale", v0_o, 0);
        end
        v0_i = 1; d0_i = 32'h77; r0_i = 0;
        @(negedge clk);
        v0_i = 0;
        chk("rst2_push_valid", v0_o, 1);
        chk("rst2_push_data", d0_o, 32'h77);

        tx = 0; rx = 0; r1_i = 1;
        for (int c = 0; c < 2200 && rx < 2000; c++) begin
            @(negedge clk);
            if (rx > 0) chk("stream_valid", v1_o, 1);
            if (v1_o) begin
                chk("stream_data", d1_o, rx);
                rx++;
            end
            v1_i = tx < 2000; d1_i = tx;
            if (v1_i && r1_o) tx++;
        end
        v1_i = 0;
        chk("stream_count", rx, 2000);

        sent = 0; got = 0;
        for (int c = 0; c < 40000 && got < 10000; c++) begin
            @(negedge clk);
            chk("rnd_level", lv2, q.size());
            if (q.size() < 7) chk("rnd_ready_hi", r2_o, 1);
            else if (q.size() == 9) chk("rnd_ready_lo", r2_o, 0);
            r2_i = 1'($urandom_range(0, 1));
            v2_i = (sent < 10000) && ($urandom_range(0, 1) == 1);
            d2_i = $urandom;
            if (v2_o && r2_i) begin
                if (q.size() == 0) chk("rnd_spurious", v2_o, 0);
                else begin
                    chk("rnd_data", d2_o, q[0]);
                    void'(q.pop_front());
                    got++;
                end
            end
            if (v2_i && r2_o) begin
                q.push_back(d2_i);
                sent++;
            end
        end
        v2_i = 0; r2_i = 0;
        chk("rnd_count", got, 10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
